// File: rtl/pixel_mem_responder.sv
// ---------------------------------------------------------------------------
// pixel_mem_responder
//
// Memory-side responder for the mandelbrot core's streaming pixel interface.
// The core pushes pixels through a write strobe and pulls them back through
// a read strobe. Each side has its own auto-incrementing pointer, and the
// core can rewind either pointer to 0. The block doubles as a synthesizable
// frame-buffer model.
//
// Parameters:
//   DATA_W  pixel width (matches i_write_data)
//   DEPTH   number of pixel entries (128x96 frame)
//   ADDR_W  pointer width, 2**ADDR_W >= DEPTH
//
// Ports:
//   i_clk              system clock, rising edge
//   i_rst              asynchronous reset, active-high
//   i_write            write strobe, one pixel stored per cycle high
//   i_reset_write_ptr  rewind write pointer to 0
//   i_write_data       pixel to store
//   i_read             read strobe, one pixel fetched per cycle high
//   i_reset_read_ptr   rewind read pointer to 0
//   o_read_data        registered pixel returned to the core
//   o_read_valid       one-cycle pulse, o_read_data updated this cycle
//   o_frame_done       one-cycle pulse after the write pointer wraps to 0
//   o_overflow         sticky, a wrap happened with no rewind since the last
//   o_wr_ptr           current write pointer (debug)
//   o_rd_ptr           current read pointer (debug)
// ---------------------------------------------------------------------------
module pixel_mem_responder #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 12288,
  parameter int ADDR_W = 14
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_write,
  input  logic              i_reset_write_ptr,
  input  logic [DATA_W-1:0] i_write_data,
  input  logic              i_read,
  input  logic              i_reset_read_ptr,
  output logic [DATA_W-1:0] o_read_data,
  output logic              o_read_valid,
  output logic              o_frame_done,
  output logic              o_overflow,
  output logic [ADDR_W-1:0] o_wr_ptr,
  output logic [ADDR_W-1:0] o_rd_ptr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // Pixel storage. It has no reset so that frame contents survive i_rst.
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [DATA_W-1:0] r_read_data;
  logic              r_read_valid;
  logic              r_frame_done;
  logic              r_overflow;
  // Set by a wrap and cleared by a write-pointer rewind. A second wrap while
  // it is still set means the core lapped the frame without rewinding.
  logic              r_wrap_armed;

  logic [ADDR_W-1:0] w_wr_addr;
  logic [ADDR_W-1:0] w_wr_inc;
  logic [ADDR_W-1:0] w_wr_next;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_rd_inc;
  logic [ADDR_W-1:0] w_rd_next;
  logic              w_wrap;

  // A pointer rewind in the same cycle as a transfer redirects that transfer
  // to address 0, so the effective address is resolved before incrementing.
  // A write is a wrap only when it really comes from the last address. A
  // rewound write lands at 0, so it is never a wrap.
  always_comb begin
    w_wr_addr = i_reset_write_ptr ? '0 : r_wr_ptr;
    w_wr_inc  = (w_wr_addr == LAST_ADDR) ? '0 : w_wr_addr + 1'b1;
    w_wr_next = i_write ? w_wr_inc : w_wr_addr;
    w_wrap    = i_write && !i_reset_write_ptr && (r_wr_ptr == LAST_ADDR);

    w_rd_addr = i_reset_read_ptr ? '0 : r_rd_ptr;
    w_rd_inc  = (w_rd_addr == LAST_ADDR) ? '0 : w_rd_addr + 1'b1;
    w_rd_next = i_read ? w_rd_inc : w_rd_addr;
  end

  // Memory write port. Strobes are ignored while reset is held, so the reset
  // term gates the write enable even though the array itself is never
  // cleared.
  always_ff @(posedge i_clk) begin
    if (i_write && !i_rst) begin
      r_mem[w_wr_addr] <= i_write_data;
    end
  end

  // Write-side pointer and frame flags. frame_done is registered from the
  // wrap, so it appears in the cycle after the write to the last address.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr     <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_wrap_armed <= 1'b0;
    end else begin
      r_wr_ptr     <= w_wr_next;
      r_frame_done <= w_wrap;
      if (w_wrap && r_wrap_armed) begin
        r_overflow <= 1'b1;
      end
      if (w_wrap) begin
        r_wrap_armed <= 1'b1;
      end else if (i_reset_write_ptr) begin
        r_wrap_armed <= 1'b0;
      end
    end
  end

  // Read side. The array is sampled with a non-blocking read, so a read and
  // a write to the same address in one cycle return the pre-write pixel.
  // read_data holds its value between reads.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_ptr     <= '0;
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
    end else begin
      r_rd_ptr     <= w_rd_next;
      r_read_valid <= i_read;
      if (i_read) begin
        r_read_data <= r_mem[w_rd_addr];
      end
    end
  end

  assign o_read_data  = r_read_data;
  assign o_read_valid = r_read_valid;
  assign o_frame_done = r_frame_done;
  assign o_overflow   = r_overflow;
  assign o_wr_ptr     = r_wr_ptr;
  assign o_rd_ptr     = r_rd_ptr;

endmodule

// File: tb/tb_pixel_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_pixel_mem_responder
//
// Self-checking bench for pixel_mem_responder. A small reference model holds
// the frame contents, the pointers and the wrap/overflow state. Each read
// pushes its expected pixel into a scoreboard queue, and that entry is popped
// when the DUT raises read_valid. A table of vectors covers the basic
// write/read stream. Hand-written sequences cover rewinds, same-address
// collisions, read-data hold, mid-burst async reset and frame wrap/overflow.
// ---------------------------------------------------------------------------
module tb_pixel_mem_responder;

  localparam int DATA_W = 4;
  localparam int DEPTH  = 12288;
  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rst;
  logic              write;
  logic              resetWritePtr;
  logic [DATA_W-1:0] writeData;
  logic              read;
  logic              resetReadPtr;
  logic [DATA_W-1:0] readData;
  logic              readValid;
  logic              frameDone;
  logic              overflow;
  logic [ADDR_W-1:0] wrPtr;
  logic [ADDR_W-1:0] rdPtr;

  always #5 clk = ~clk;

  pixel_mem_responder #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_write          (write),
    .i_reset_write_ptr(resetWritePtr),
    .i_write_data     (writeData),
    .i_read           (read),
    .i_reset_read_ptr (resetReadPtr),
    .o_read_data      (readData),
    .o_read_valid     (readValid),
    .o_frame_done     (frameDone),
    .o_overflow       (overflow),
    .o_wr_ptr         (wrPtr),
    .o_rd_ptr         (rdPtr)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [DATA_W-1:0] mMem [DEPTH];
  int                mWr;
  int                mRd;
  bit                mArmed;
  bit                mOv;
  bit                mFd;
  logic [DATA_W-1:0] mLast;
  logic [DATA_W-1:0] sbQ [$];

  typedef struct {
    logic              w;
    logic              rwp;
    logic [DATA_W-1:0] d;
    logic              r;
    logic              rrp;
    logic [ADDR_W-1:0] expWr;
    logic [ADDR_W-1:0] expRd;
    logic              expValid;
    logic [DATA_W-1:0] expData;
  } vec_t;

  vec_t vecs [17];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic modelReset();
    mWr   = 0;
    mRd   = 0;
    mArmed = 1'b0;
    mOv   = 1'b0;
    mFd   = 1'b0;
    mLast = '0;
    sbQ.delete();
  endtask

  // Compares everything the DUT shows after an edge against the model.
  task automatic checkOutput();
    logic expValid;
    expValid = (sbQ.size() != 0);
    cmp("read_valid", 32'(readValid), 32'(expValid));
    if (expValid) mLast = sbQ.pop_front();
    cmp("read_data", 32'(readData), 32'(mLast));
    cmp("wr_ptr", 32'(wrPtr), 32'(mWr));
    cmp("rd_ptr", 32'(rdPtr), 32'(mRd));
    cmp("frame_done", 32'(frameDone), 32'(mFd));
    cmp("overflow", 32'(overflow), 32'(mOv));
  endtask

  // Drives one cycle of strobes, advances the model, waits for the edge and
  // checks the result.
  task automatic applyStimulus(input logic w, input logic rwp, input logic [DATA_W-1:0] d,
                               input logic r, input logic rrp);
    int  a;
    bit  wrap;
    write         = w;
    resetWritePtr = rwp;
    writeData     = d;
    read          = r;
    resetReadPtr  = rrp;
    // The read is modelled before the write so that a same-address
    // collision returns the old pixel.
    if (r) begin
      a = rrp ? 0 : mRd;
      sbQ.push_back(mMem[a]);
      mRd = (a == DEPTH - 1) ? 0 : a + 1;
    end else if (rrp) begin
      mRd = 0;
    end
    wrap = 1'b0;
    if (w) begin
      a = rwp ? 0 : mWr;
      wrap = !rwp && (mWr == DEPTH - 1);
      mMem[a] = d;
      mWr = (a == DEPTH - 1) ? 0 : a + 1;
    end else if (rwp) begin
      mWr = 0;
    end
    if (rwp) mArmed = 1'b0;
    if (wrap) begin
      if (mArmed) mOv = 1'b1;
      mArmed = 1'b1;
    end
    mFd = wrap;
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic resetDut();
    rst = 1'b1;
    write = 1'b0; resetWritePtr = 1'b0; writeData = '0;
    read = 1'b0; resetReadPtr = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
    cmp("rst_wr_ptr", 32'(wrPtr), 32'd0);
    cmp("rst_rd_ptr", 32'(rdPtr), 32'd0);
    cmp("rst_read_data", 32'(readData), 32'd0);
    cmp("rst_read_valid", 32'(readValid), 32'd0);
    cmp("rst_frame_done", 32'(frameDone), 32'd0);
    cmp("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    int fdCount;

    // Vector table: eight writes, a read-pointer rewind, eight reads
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{1'b1, 1'b0, DATA_W'(i + 1), 1'b0, 1'b0,
                  ADDR_W'(i + 1), ADDR_W'(0), 1'b0, DATA_W'(0)};
    end
    vecs[8] = '{1'b0, 1'b0, DATA_W'(0), 1'b0, 1'b1,
                ADDR_W'(8), ADDR_W'(0), 1'b0, DATA_W'(0)};
    for (int k = 0; k < 8; k++) begin
      vecs[9 + k] = '{1'b0, 1'b0, DATA_W'(0), 1'b1, 1'b0,
                      ADDR_W'(8), ADDR_W'(k + 1), 1'b1, DATA_W'(k + 1)};
    end

    $display("[TB] reset");
    resetDut();

    $display("[TB] table-driven write/read stream");
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].w, vecs[i].rwp, vecs[i].d, vecs[i].r, vecs[i].rrp);
      cmp($sformatf("tbl%0d_wr_ptr", i), 32'(wrPtr), 32'(vecs[i].expWr));
      cmp($sformatf("tbl%0d_rd_ptr", i), 32'(rdPtr), 32'(vecs[i].expRd));
      cmp($sformatf("tbl%0d_valid", i), 32'(readValid), 32'(vecs[i].expValid));
      cmp($sformatf("tbl%0d_data", i), 32'(readData), 32'(vecs[i].expData));
    end

    $display("[TB] rewind together with transfer");
    applyStimulus(1'b1, 1'b1, 4'hA, 1'b0, 1'b0);
    cmp("rwp_write_wr_ptr", 32'(wrPtr), 32'd1);
    cmp("rwp_write_no_fd", 32'(frameDone), 32'd0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
    cmp("rrp_read_data", 32'(readData), 32'hA);
    cmp("rrp_read_rd_ptr", 32'(rdPtr), 32'd1);

    $display("[TB] same-address read/write collision");
    applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'hA, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'h2, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'h3, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'h5, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'hA, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'h2, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'h3, 1'b0, 1'b0);
    cmp("collide_setup_ptrs", 32'({wrPtr, rdPtr}), 32'({14'd3, 14'd3}));
    applyStimulus(1'b1, 1'b0, 4'hC, 1'b1, 1'b0);
    cmp("collide_old_data", 32'(readData), 32'h5);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
    cmp("collide_reread", 32'(readData), 32'hC);

    $display("[TB] read_data hold");
    applyStimulus(1'b1, 1'b0, 4'h7, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
    cmp("hold_first", 32'(readData), 32'h7);
    for (int i = 0; i < 5; i++) begin
      idle();
      cmp($sformatf("hold%0d_data", i), 32'(readData), 32'h7);
      cmp($sformatf("hold%0d_valid", i), 32'(readValid), 32'd0);
    end

    $display("[TB] asynchronous reset mid-burst");
    applyStimulus(1'b1, 1'b0, 4'h9, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'h8, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    cmp("async_wr_ptr", 32'(wrPtr), 32'd0);
    cmp("async_rd_ptr", 32'(rdPtr), 32'd0);
    cmp("async_read_data", 32'(readData), 32'd0);
    cmp("async_read_valid", 32'(readValid), 32'd0);
    cmp("async_overflow", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;
    cmp("async_strobe_ignored", 32'(wrPtr), 32'd0);
    rst = 1'b0;
    modelReset();
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
    cmp("post_rst_read0", 32'(readData), 32'hA);

    $display("[TB] full-frame wrap and overflow");
    fdCount = 0;
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, DATA_W'(i), 1'b0, 1'b0);
      if (frameDone) fdCount++;
    end
    cmp("fill_fd_count", 32'(fdCount), 32'd1);
    cmp("fill_fd_last", 32'(frameDone), 32'd1);
    cmp("fill_wr_ptr", 32'(wrPtr), 32'd0);
    cmp("fill_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, DATA_W'(i + 3), 1'b0, 1'b0);
    end
    cmp("lap_overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 3; i++) idle();
    cmp("lap_overflow_sticky", 32'(overflow), 32'd1);

    $display("[TB] rewind clears overflow arming");
    resetDut();
    for (int i = 0; i < DEPTH - 1; i++) begin
      applyStimulus(1'b1, 1'b0, DATA_W'(i), 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 4'hA, 1'b0, 1'b0);
    cmp("rwp_at_last_wr_ptr", 32'(wrPtr), 32'd1);
    cmp("rwp_at_last_no_fd", 32'(frameDone), 32'd0);
    for (int i = 1; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, DATA_W'(i), 1'b0, 1'b0);
    end
    cmp("arm_first_wrap_fd", 32'(frameDone), 32'd1);
    applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, DATA_W'(i), 1'b0, 1'b0);
    end
    cmp("arm_second_wrap_fd", 32'(frameDone), 32'd1);
    cmp("arm_no_overflow", 32'(overflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
